avr_decode: RTL and testbench

//  Decode stage directly downstream of avr_fetch. Consumes cur_instr, classifies each word and

---
 rtl/avr_decode_if.sv | 27 ++
 rtl/avr_decode.sv | 177 +++++++++++++++++
 tb/tb_avr_decode.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_decode_if.sv
// Port bundle between the fetch/execute side (master) and avr_decode (slave).
// Handshake: execute takes the op in any cycle where op_valid=1 and ex_stall=0;
// while ex_stall=1 the decoder holds every op_* output and requests pc_src=HOLD.
interface avr_decode_if #(
  parameter int PC_W = 16
);
  logic [15:0]     cur_instr;
  logic            ex_stall;
  logic [2:0]      pc_src;
  logic [PC_W-1:0] jmp;
  logic            op_valid;
  logic [3:0]      op_class;
  logic [3:0]      alu_op;
  logic [4:0]      rd;
  logic [4:0]      rr;
  logic [15:0]     imm;
  logic [1:0]      dbg_state;

  modport master (
    output cur_instr, ex_stall,
    input  pc_src, jmp, op_valid, op_class, alu_op, rd, rr, imm, dbg_state
  );
  modport slave (
    input  cur_instr, ex_stall,
    output pc_src, jmp, op_valid, op_class, alu_op, rd, rr, imm, dbg_state
  );
endinterface

// File: rtl/avr_decode.sv
// AVR decode stage: classifies fetched words, extracts operand fields, steers
// fetch (pc_src/jmp) and sequences two-word ops and post-jump flushes.
module avr_decode #(
  parameter int PC_W      = 16,
  parameter int FLUSH_CYC = 1
) (
  input logic         CLK,
  input logic         RST,
  avr_decode_if.slave bus
);
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

  localparam logic [2:0] PC_INC  = 3'b000;
  localparam logic [2:0] PC_HOLD = 3'b010;
  localparam logic [2:0] PC_REL  = 3'b100;
  localparam logic [2:0] PC_ABS  = 3'b101;

  localparam logic [3:0] CL_NOP     = 4'd0;
  localparam logic [3:0] CL_ALU_RR  = 4'd1;
  localparam logic [3:0] CL_ALU_IMM = 4'd2;
  localparam logic [3:0] CL_LDS     = 4'd3;
  localparam logic [3:0] CL_STS     = 4'd4;
  localparam logic [3:0] CL_RJMP    = 4'd5;
  localparam logic [3:0] CL_JMP     = 4'd6;
  localparam logic [3:0] CL_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {S_BOOT, S_EXEC, S_WORD2, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [3:0]       pend_class_q, pend_class_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             op_valid_q, op_valid_d;
  logic [3:0]       op_class_q, op_class_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rr_q, rr_d;
  logic [15:0]      imm_q, imm_d;
  logic [2:0]       pc_src_c;
  logic [PC_W-1:0]  jmp_c;
  logic [15:0]      instr;

  assign instr = bus.cur_instr;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    pend_class_d = pend_class_q;
    pend_rd_d    = pend_rd_q;
    op_valid_d   = 1'b0;
    op_class_d   = CL_NOP;
    alu_op_d     = '0;
    rd_d         = '0;
    rr_d         = '0;
    imm_d        = '0;
    pc_src_c     = PC_INC;
    jmp_c        = '0;
    if (bus.ex_stall) begin
      // Freeze everything so a held op, pending word 2 or flush survives the stall.
      pc_src_c   = PC_HOLD;
      op_valid_d = op_valid_q;
      op_class_d = op_class_q;
      alu_op_d   = alu_op_q;
      rd_d       = rd_q;
      rr_d       = rr_q;
      imm_d      = imm_q;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) state_d = S_EXEC;
          else flush_cnt_d = flush_cnt_q + 1'b1;
        end
        S_WORD2: begin
          op_valid_d = 1'b1;
          op_class_d = pend_class_q;
          if (pend_class_q == CL_JMP) begin
            pc_src_c    = PC_ABS;
            jmp_c       = PC_W'(instr);
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end else begin
            rd_d    = pend_rd_q;
            imm_d   = instr;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          op_valid_d = 1'b1;
          casez (instr)
            16'h0000: op_class_d = CL_NOP;
            16'b0000_1???_????_????, 16'b0001_01??_????_????,
            16'b0001_1???_????_????, 16'b0010_????_????_????: begin
              op_class_d = CL_ALU_RR;
              alu_op_d   = instr[13:10];
              rd_d       = instr[8:4];
              rr_d       = {instr[9], instr[3:0]};
            end
            16'b0011_????_????_????, 16'b0101_????_????_????,
            16'b011?_????_????_????, 16'b1110_????_????_????: begin
              op_class_d = CL_ALU_IMM;
              alu_op_d   = instr[15:12];
              rd_d       = {1'b1, instr[7:4]};
              imm_d      = {8'h00, instr[11:8], instr[3:0]};
            end
            16'b1100_????_????_????: begin
              op_class_d  = CL_RJMP;
              pc_src_c    = PC_REL;
              jmp_c       = {{(PC_W-12){instr[11]}}, instr[11:0]};
              state_d     = S_FLUSH;
              flush_cnt_d = '0;
            end
            16'b1001_010?_????_110?: begin
              op_valid_d   = 1'b0;
              pend_class_d = CL_JMP;
              pend_rd_d    = '0;
              state_d      = S_WORD2;
            end
            16'b1001_000?_????_0000, 16'b1001_001?_????_0000: begin
              op_valid_d   = 1'b0;
              pend_class_d = instr[9] ? CL_STS : CL_LDS;
              pend_rd_d    = instr[8:4];
              state_d      = S_WORD2;
            end
            default: op_class_d = CL_ILLEGAL;
          endcase
        end
        default: state_d = S_BOOT;
      endcase
    end
    // Fetch samples pc_src on the same edge that applies reset, so hold it there.
    if (RST) begin
      pc_src_c = PC_HOLD;
      jmp_c    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_BOOT;
      flush_cnt_q  <= '0;
      pend_class_q <= '0;
      pend_rd_q    <= '0;
      op_valid_q   <= 1'b0;
      op_class_q   <= '0;
      alu_op_q     <= '0;
      rd_q         <= '0;
      rr_q         <= '0;
      imm_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      pend_class_q <= pend_class_d;
      pend_rd_q    <= pend_rd_d;
      op_valid_q   <= op_valid_d;
      op_class_q   <= op_class_d;
      alu_op_q     <= alu_op_d;
      rd_q         <= rd_d;
      rr_q         <= rr_d;
      imm_q        <= imm_d;
    end
  end

  assign bus.pc_src    = pc_src_c;
  assign bus.jmp       = jmp_c;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_class  = op_class_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rd        = rd_q;
  assign bus.rr        = rr_q;
  assign bus.imm       = imm_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_avr_decode.sv
// Bench for avr_decode: directed scenarios plus a randomized instruction stream
// checked against an instruction-level reference model.
module tb_avr_decode;
  localparam int PC_W      = 16;
  localparam int FLUSH_CYC = 1;

  localparam logic [2:0] P_INC  = 3'b000;
  localparam logic [2:0] P_HOLD = 3'b010;
  localparam logic [2:0] P_REL  = 3'b100;
  localparam logic [2:0] P_ABS  = 3'b101;

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_RR   = 4'd1;
  localparam logic [3:0] C_IMM  = 4'd2;
  localparam logic [3:0] C_LDS  = 4'd3;
  localparam logic [3:0] C_STS  = 4'd4;
  localparam logic [3:0] C_RJMP = 4'd5;
  localparam logic [3:0] C_JMP  = 4'd6;
  localparam logic [3:0] C_ILL  = 4'd15;

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rr;
    logic [15:0] imm;
  } op_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [33:0] exp_q[$];

  avr_decode_if #(.PC_W(PC_W)) bus ();

  avr_decode #(.PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic op_t ref_op(input logic [15:0] w, input logic [15:0] w2);
    op_t o;
    int  wi, top6, top4, hi7;
    o = '0;
    wi = int'(w);
    top6 = wi >> 10;
    top4 = wi >> 12;
    hi7  = wi >> 9;
    if (wi == 0) o.cls = C_NOP;
    else if (top6 inside {2, 3, 5, 6, 7, 8, 9, 10, 11}) begin
      o.cls    = C_RR;
      o.alu_op = 4'(top6 % 16);
      o.rd     = 5'((wi / 16) % 32);
      o.rr     = 5'(((wi / 512) % 2) * 16 + wi % 16);
    end else if (top4 inside {3, 5, 6, 7, 14}) begin
      o.cls    = C_IMM;
      o.alu_op = 4'(top4);
      o.rd     = 5'(16 + (wi / 16) % 16);
      o.imm    = 16'(((wi / 256) % 16) * 16 + wi % 16);
    end else if (top4 == 12) o.cls = C_RJMP;
    else if (hi7 == 'b1001010 && (wi / 2) % 8 == 6) o.cls = C_JMP;
    else if ((hi7 == 'b1001000 || hi7 == 'b1001001) && wi % 16 == 0) begin
      o.cls = (hi7 == 'b1001000) ? C_LDS : C_STS;
      o.rd  = 5'((wi / 16) % 32);
      o.imm = w2;
    end else o.cls = C_ILL;
    return o;
  endfunction

  function automatic logic [15:0] rel_jmp(input logic [15:0] w);
    int k;
    k = int'(w) % 4096;
    if (k >= 2048) k = k - 4096;
    return 16'(k);
  endfunction

  // ---------------- driver tasks ----------------
  // Waits for the next edge, applies inputs for the new cycle, lets comb logic settle.
  task automatic cyc(input logic [15:0] w, input logic s);
    @(posedge CLK);
    #1;
    bus.cur_instr = w;
    bus.ex_stall  = s;
    #1;
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.ex_stall  = 1'b0;
    bus.cur_instr = 16'h0000;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (FLUSH_CYC) cyc(16'($urandom), 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1; bus.ex_stall = 1'b1; bus.cur_instr = 16'h0E31;
    #1;
    n_cmp++;
    if (bus.pc_src !== P_HOLD || bus.jmp !== 16'h0) begin
      n_bad++; $display("FAIL rst_pc: pc_src=%b jmp=%h want %b 0000", bus.pc_src, bus.jmp, P_HOLD);
    end
    @(posedge CLK);
    #1;
    n_cmp++;
    if ({bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm} !== 35'h0) begin
      n_bad++; $display("FAIL rst_ops: valid=%b class=%h alu=%h rd=%0d rr=%0d imm=%h want all 0",
                        bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0; bus.ex_stall = 1'b0;
    #1;
    n_cmp++;
    if (bus.pc_src !== P_INC || bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_boot: pc_src=%b valid=%b want %b 0", bus.pc_src, bus.op_valid, P_INC);
    end
    cyc(16'h0E31, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_INC || bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_discard: pc_src=%b valid=%b want %b 0", bus.pc_src, bus.op_valid, P_INC);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_dropped_word: valid=%b want 0", bus.op_valid);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b1 || bus.op_class !== C_NOP) begin
      n_bad++; $display("FAIL rst_first_nop: valid=%b class=%h want 1 0", bus.op_valid, bus.op_class);
    end
  endtask

  task automatic test_alu();
    reset_dut();
    cyc(16'h0E31, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_INC) begin
      n_bad++; $display("FAIL add_pc: pc_src=%b want %b", bus.pc_src, P_INC);
    end
    cyc(16'hEA45, 1'b0);
    n_cmp++;
    if ({bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm} !==
        {1'b1, C_RR, 4'h3, 5'd3, 5'd17, 16'h0000}) begin
      n_bad++; $display("FAIL add_op: valid=%b class=%h alu=%h rd=%0d rr=%0d imm=%h want 1 1 3 3 17 0000",
                        bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if ({bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm} !==
        {1'b1, C_IMM, 4'hE, 5'd20, 5'd0, 16'h00A5}) begin
      n_bad++; $display("FAIL ldi_op: valid=%b class=%h alu=%h rd=%0d rr=%0d imm=%h want 1 2 e 20 0 00a5",
                        bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm);
    end
  endtask

  task automatic test_rjmp();
    reset_dut();
    cyc(16'hCFFD, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_REL || bus.jmp !== 16'hFFFD) begin
      n_bad++; $display("FAIL rjmp_pc: pc_src=%b jmp=%h want %b fffd", bus.pc_src, bus.jmp, P_REL);
    end
    cyc(16'h1234, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b1 || bus.op_class !== C_RJMP || bus.pc_src !== P_INC) begin
      n_bad++; $display("FAIL rjmp_op: valid=%b class=%h pc_src=%b want 1 5 %b",
                        bus.op_valid, bus.op_class, bus.pc_src, P_INC);
    end
    cyc(16'h0E31, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL rjmp_flush: valid=%b want 0", bus.op_valid);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b1 || bus.op_class !== C_RR) begin
      n_bad++; $display("FAIL rjmp_resume: valid=%b class=%h want 1 1", bus.op_valid, bus.op_class);
    end
  endtask

  task automatic test_jmp();
    reset_dut();
    cyc(16'h940C, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_INC || bus.jmp !== 16'h0) begin
      n_bad++; $display("FAIL jmp_w1: pc_src=%b jmp=%h want %b 0000", bus.pc_src, bus.jmp, P_INC);
    end
    cyc(16'h0050, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_ABS || bus.jmp !== 16'h0050 || bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL jmp_w2: pc_src=%b jmp=%h valid=%b want %b 0050 0",
                        bus.pc_src, bus.jmp, bus.op_valid, P_ABS);
    end
    cyc(16'hFFFF, 1'b0);
    n_cmp++;
    if ({bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm} !==
        {1'b1, C_JMP, 4'h0, 5'd0, 5'd0, 16'h0000} || bus.pc_src !== P_INC) begin
      n_bad++; $display("FAIL jmp_op: valid=%b class=%h pc_src=%b want 1 6 %b",
                        bus.op_valid, bus.op_class, bus.pc_src, P_INC);
    end
    cyc(16'h0E31, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL jmp_flush: valid=%b want 0", bus.op_valid);
    end
  endtask

  task automatic test_lds_stall();
    reset_dut();
    cyc(16'h9050, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(16'h0100, 1'b1);
      n_cmp++;
      if (bus.pc_src !== P_HOLD || bus.jmp !== 16'h0 || bus.op_valid !== 1'b0) begin
        n_bad++; $display("FAIL lds_stall[%0d]: pc_src=%b jmp=%h valid=%b want %b 0000 0",
                          i, bus.pc_src, bus.jmp, bus.op_valid, P_HOLD);
      end
    end
    cyc(16'h0100, 1'b0);
    n_cmp++;
    if (bus.pc_src !== P_INC || bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL lds_w2: pc_src=%b valid=%b want %b 0", bus.pc_src, bus.op_valid, P_INC);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if ({bus.op_valid, bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm} !==
        {1'b1, C_LDS, 4'h0, 5'd5, 5'd0, 16'h0100}) begin
      n_bad++; $display("FAIL lds_op: valid=%b class=%h rd=%0d imm=%h want 1 3 5 0100",
                        bus.op_valid, bus.op_class, bus.rd, bus.imm);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if (bus.op_class !== C_NOP) begin
      n_bad++; $display("FAIL lds_once: class=%h want 0", bus.op_class);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    cyc(16'h940C, 1'b0);
    cyc(16'h0050, 1'b1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (bus.pc_src !== P_HOLD || bus.jmp !== 16'h0) begin
      n_bad++; $display("FAIL midrst_pc: pc_src=%b jmp=%h want %b 0000", bus.pc_src, bus.jmp, P_HOLD);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0; bus.ex_stall = 1'b0;
    #1;
    n_cmp++;
    if (bus.pc_src !== P_INC || bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_boot: pc_src=%b valid=%b want %b 0", bus.pc_src, bus.op_valid, P_INC);
    end
    cyc(16'h0050, 1'b0);
    cyc(16'hFFFF, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_no_partial: valid=%b want 0", bus.op_valid);
    end
    cyc(16'h0000, 1'b0);
    n_cmp++;
    if (bus.op_valid !== 1'b1 || bus.op_class !== C_ILL) begin
      n_bad++; $display("FAIL illegal_op: valid=%b class=%h want 1 f", bus.op_valid, bus.op_class);
    end
    // Reset must beat a stall that is holding a valid op.
    cyc(16'h0E31, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1; bus.ex_stall = 1'b1;
    #1;
    n_cmp++;
    if (bus.op_valid !== 1'b1 || bus.op_class !== C_RR) begin
      n_bad++; $display("FAIL held_op: valid=%b class=%h want 1 1", bus.op_valid, bus.op_class);
    end
    @(posedge CLK);
    #1;
    n_cmp++;
    if (bus.op_valid !== 1'b0 || bus.op_class !== C_NOP) begin
      n_bad++; $display("FAIL rst_over_stall: valid=%b class=%h want 0 0", bus.op_valid, bus.op_class);
    end
    RST = 1'b0; bus.ex_stall = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] sw[$];
    logic [2:0]  sp[$];
    logic [15:0] sj[$];
    int rr_tops[9] = '{2, 3, 5, 6, 7, 8, 9, 10, 11};
    int imm_tops[5] = '{3, 5, 6, 7, 14};
    int idx, budget, kind;
    logic s;
    logic [15:0] w, w2, ep_j;
    logic [2:0] ep;
    op_t o, got;
    exp_q.delete();
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 7);
      w2 = 16'($urandom);
      case (kind)
        0: w = 16'h0000;
        1: w = 16'((rr_tops[$urandom_range(0, 8)] << 10) | $urandom_range(0, 1023));
        2: w = 16'((imm_tops[$urandom_range(0, 4)] << 12) | $urandom_range(0, 4095));
        3: w = 16'((12 << 12) | $urandom_range(0, 4095));
        4: w = 16'(('b1001010 << 9) | ($urandom_range(0, 31) << 4) | (6 << 1) | $urandom_range(0, 1));
        5: w = 16'(('b1001000 << 9) | ($urandom_range(0, 31) << 4));
        6: w = 16'(('b1001001 << 9) | ($urandom_range(0, 31) << 4));
        default: w = 16'($urandom);
      endcase
      o = ref_op(w, w2);
      sw.push_back(w);
      sp.push_back(o.cls == C_RJMP ? P_REL : P_INC);
      sj.push_back(o.cls == C_RJMP ? rel_jmp(w) : 16'h0000);
      if (o.cls inside {C_JMP, C_LDS, C_STS}) begin
        sw.push_back(w2);
        sp.push_back(o.cls == C_JMP ? P_ABS : P_INC);
        sj.push_back(o.cls == C_JMP ? w2 : 16'h0000);
      end
      if (o.cls inside {C_RJMP, C_JMP}) begin
        for (int f = 0; f < FLUSH_CYC; f++) begin
          sw.push_back(16'($urandom));
          sp.push_back(P_INC);
          sj.push_back(16'h0000);
        end
      end
      exp_q.push_back(o);
    end

    reset_dut();
    idx = 0;
    budget = 0;
    while (budget < 4000) begin
      if (idx < sw.size()) begin
        s = ($urandom_range(0, 3) == 0);
        cyc(sw[idx], s);
        ep   = s ? P_HOLD : sp[idx];
        ep_j = s ? 16'h0000 : sj[idx];
        n_cmp++;
        if (bus.pc_src !== ep || bus.jmp !== ep_j) begin
          n_bad++; $display("FAIL rand_pc slot %0d: pc_src=%b jmp=%h want %b %h",
                            idx, bus.pc_src, bus.jmp, ep, ep_j);
        end
      end else begin
        s = 1'b0;
        cyc(16'h0000, 1'b0);
      end
      if (bus.op_valid && !s) begin
        got = {bus.op_class, bus.alu_op, bus.rd, bus.rr, bus.imm};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_op: unexpected op %h, none expected", got);
        end else begin
          o = exp_q.pop_front();
          if (got !== o) begin
            n_bad++; $display("FAIL rand_op: got class=%h alu=%h rd=%0d rr=%0d imm=%h want class=%h alu=%h rd=%0d rr=%0d imm=%h",
                              got.cls, got.alu_op, got.rd, got.rr, got.imm, o.cls, o.alu_op, o.rd, o.rr, o.imm);
          end
        end
      end
      if (idx >= sw.size()) break;
      if (!s) idx++;
      budget++;
    end
    n_cmp++;
    if (idx != sw.size() || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rand_drain: slots done=%0d of %0d, ops left=%0d want 0",
                        idx, sw.size(), exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.cur_instr = 16'h0000;
    bus.ex_stall  = 1'b0;
    test_reset();
    test_alu();
    test_rjmp();
    test_jmp();
    test_lds_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
